rr_arbiter_fsm: RTL



---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter_fsm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter.
// State encoding and the one-hot helper.
package rr_arb_pkg;

  localparam int STATE_W = 2;
  localparam int MAX_REQ = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot(
    input logic [2:0] idx
  );
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set request
// at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  sel,
  output logic             valid
);

  int idx;

  // Walk upward from ptr; the first hit wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter: IDLE -> GRANT -> RELEASE,
// with watchdog on the grant hold time.
module rr_arbiter_fsm
  import rr_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [ID_W-1:0]  pick_sel;
  logic             pick_valid;
  logic             rel_norm;
  logic             rel_to;
  logic [ID_W-1:0]  ptr_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  assign rel_norm = done[id_q] | ~req[id_q];
  assign rel_to   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ptr_nxt  = (id_q == ID_W'(N_REQ - 1))
                  ? '0 : id_q + 1'b1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(onehot(3'(pick_sel)));
          id_d    = pick_sel;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (rel_norm || rel_to) begin
          state_d = RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          to_d    = ~rel_norm;
          cnt_d   = '0;
          ptr_d   = ptr_nxt;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule
